// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        HZ_RUN        = 1'b0,
        HZ_LOAD_STALL = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Width of a register-file select; a single file still needs one bit.
    function automatic int rfWidth(input int numRf);
        return (numRf > 1) ? $clog2(numRf) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_forward_sel.sv
// Operand forwarding select for one E-stage source: M result beats W result.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int RF_W   = 1
) (
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [RF_W-1:0]   srcFile,
    input  logic              regWriteM,
    input  logic [ADDR_W-1:0] wAddrM,
    input  logic [RF_W-1:0]   wFileM,
    input  logic              regWriteW,
    input  logic [ADDR_W-1:0] wAddrW,
    input  logic [RF_W-1:0]   wFileW,
    output logic [1:0]        fwdSel
);

    logic srcIsZero;
    logic matchM;
    logic matchW;

    // Scalar register 0 is hard-wired, so it can never take a forwarded value.
    assign srcIsZero = (srcAddr == '0) && (srcFile == '0);
    assign matchM    = regWriteM && !srcIsZero && (srcAddr == wAddrM) && (srcFile == wFileM);
    assign matchW    = regWriteW && !srcIsZero && (srcAddr == wAddrW) && (srcFile == wFileW);

    // Priority pick: the younger M-stage result is the most recent value.
    always_comb begin
        fwdSel = FWD_NONE;
        if (matchM) begin
            fwdSel = FWD_MEM;
        end else if (matchW) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: forwarding, load-use stalls, branch flushes, busy freeze,
// stall-cycle statistics and a sticky busy-timeout flag.
//
//   state          | meaning
//   ---------------+-------------------------------------------------------
//   HZ_RUN         | normal issue; a load-use hazard here starts the stall
//   HZ_LOAD_STALL  | further load-use stall cycles, lcnt cycles remaining
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int ADDR_W   = 3,
    parameter  int NUM_RF   = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int TIMEOUT  = 255,
    parameter  int CNT_W    = 16,
    localparam int RF_W     = rfWidth(NUM_RF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] RA1E,
    input  logic [ADDR_W-1:0] RA2E,
    input  logic [RF_W-1:0]   RF1D,
    input  logic [RF_W-1:0]   RF2D,
    input  logic [RF_W-1:0]   RF1E,
    input  logic [RF_W-1:0]   RF2E,
    input  logic [ADDR_W-1:0] WA3E,
    input  logic [ADDR_W-1:0] WA3M,
    input  logic [ADDR_W-1:0] WA3W,
    input  logic [RF_W-1:0]   WF3E,
    input  logic [RF_W-1:0]   WF3M,
    input  logic [RF_W-1:0]   WF3W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              Busy,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCount,
    output logic              BusyTimeout
);

    localparam int LCNT_W = $clog2(LOAD_LAT + 1);
    localparam int BCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [LCNT_W-1:0] LCNT_START = LCNT_W'(LOAD_LAT - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX   = BCNT_W'(TIMEOUT);

    hz_state_t          state;
    logic [LCNT_W-1:0]  lcnt;
    logic [BCNT_W-1:0]  bcnt;
    logic [1:0]         fwdA;
    logic [1:0]         fwdB;
    logic               use1;
    logic               use2;
    logic               loadUse;

    forward_sel #(.ADDR_W(ADDR_W), .RF_W(RF_W)) uFwdA (
        .srcAddr   (RA1E),
        .srcFile   (RF1E),
        .regWriteM (RegWriteM),
        .wAddrM    (WA3M),
        .wFileM    (WF3M),
        .regWriteW (RegWriteW),
        .wAddrW    (WA3W),
        .wFileW    (WF3W),
        .fwdSel    (fwdA)
    );

    forward_sel #(.ADDR_W(ADDR_W), .RF_W(RF_W)) uFwdB (
        .srcAddr   (RA2E),
        .srcFile   (RF2E),
        .regWriteM (RegWriteM),
        .wAddrM    (WA3M),
        .wFileM    (WF3M),
        .regWriteW (RegWriteW),
        .wAddrW    (WA3W),
        .wFileW    (WF3W),
        .fwdSel    (fwdB)
    );

    assign ForwardAE = rst_n ? fwdA : FWD_NONE;
    assign ForwardBE = rst_n ? fwdB : FWD_NONE;

    // A load in E whose destination is a D-stage source (never scalar r0).
    assign use1    = (RA1D == WA3E) && (RF1D == WF3E) && !((RA1D == '0) && (RF1D == '0));
    assign use2    = (RA2D == WA3E) && (RF2D == WF3E) && !((RA2D == '0) && (RF2D == '0));
    assign loadUse = MemtoRegE && (use1 || use2);

    // Stall/flush priority: reset, busy freeze, branch, load-use stall.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (Busy) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if ((state == HZ_LOAD_STALL) || loadUse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Load-stall FSM; Busy freezes it, a taken branch aborts any pending stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HZ_RUN;
            lcnt  <= '0;
        end else if (!Busy) begin
            if (BranchTakenE) begin
                state <= HZ_RUN;
                lcnt  <= '0;
            end else if (state == HZ_LOAD_STALL) begin
                if (lcnt <= LCNT_W'(1)) begin
                    state <= HZ_RUN;
                    lcnt  <= '0;
                end else begin
                    lcnt <= lcnt - LCNT_W'(1);
                end
            end else if (loadUse && (LOAD_LAT > 1)) begin
                state <= HZ_LOAD_STALL;
                lcnt  <= LCNT_START;
            end
        end
    end

    // Consecutive-busy counter with sticky timeout, plus saturating stall count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt        <= '0;
            BusyTimeout <= 1'b0;
            StallCount  <= '0;
        end else begin
            if (!Busy) begin
                bcnt <= '0;
            end else if (bcnt != BCNT_MAX) begin
                bcnt <= bcnt + BCNT_W'(1);
            end
            if (Busy && (bcnt == BCNT_MAX - BCNT_W'(1))) begin
                BusyTimeout <= 1'b1;
            end
            if (StallF && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with LOAD_LAT=3, TIMEOUT=4, CNT_W=4.
module tb_pipe_hazard_ctrl;

    localparam int ADDR_W = 3;
    localparam int RF_W   = 1;
    localparam int CNT_W  = 4;

    // control word order: {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE}
    localparam logic [6:0] CTL_IDLE  = 7'b0000000;
    localparam logic [6:0] CTL_LOAD  = 7'b1100001;
    localparam logic [6:0] CTL_BUSY  = 7'b1111100;
    localparam logic [6:0] CTL_FLUSH = 7'b0000011;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic [RF_W-1:0]   RF1D, RF2D, RF1E, RF2E, WF3E, WF3M, WF3W;
    logic              RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, Busy;
    logic              StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [CNT_W-1:0]  StallCount;
    logic              BusyTimeout;
    logic [6:0]        ctl;

    int checks   = 0;
    int failures = 0;

    assign ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

    pipe_hazard_ctrl #(
        .ADDR_W(ADDR_W), .NUM_RF(2), .LOAD_LAT(3), .TIMEOUT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .RF1D(RF1D), .RF2D(RF2D), .RF1E(RF1E), .RF2E(RF2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .WF3E(WF3E), .WF3M(WF3M), .WF3W(WF3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .Busy(Busy),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .BusyTimeout(BusyTimeout)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
        RF1D = '0; RF2D = '0; RF1E = '0; RF2E = '0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        WF3E = '0; WF3M = '0; WF3W = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0; Busy = 1'b0;
    endtask

    task automatic fwdVec(input string tag,
                          input logic [2:0] ra1, input logic rf1,
                          input logic [2:0] ra2, input logic rf2,
                          input logic [2:0] wam, input logic wfm, input logic rwm,
                          input logic [2:0] waw, input logic wfw, input logic rww,
                          input logic [1:0] expA, input logic [1:0] expB);
        RA1E = ra1; RF1E = rf1; RA2E = ra2; RF2E = rf2;
        WA3M = wam; WF3M = wfm; RegWriteM = rwm;
        WA3W = waw; WF3W = wfw; RegWriteW = rww;
        #1;
        checkVal({tag, "_A"}, 32'(ForwardAE), 32'(expA));
        checkVal({tag, "_B"}, 32'(ForwardBE), 32'(expB));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        clearInputs();
        rst_n = 1'b0;
        #1;
        RegWriteM = 1'b1; WA3M = 3'd3; WF3M = 1'b1; RA1E = 3'd3; RF1E = 1'b1;
        #1;
        checkVal("rst_ctl", 32'(ctl), 32'(CTL_FLUSH));
        checkVal("rst_fwdA", 32'(ForwardAE), 32'(2'b00));
        tick();
        tick();
        checkVal("rst_count", 32'(StallCount), 32'd0);
        checkVal("rst_timeout", 32'(BusyTimeout), 32'd0);
        rst_n = 1'b1;
        clearInputs();
        #1;
        checkVal("run_idle", 32'(ctl), 32'(CTL_IDLE));

        // forwarding vectors
        fwdVec("fwd_mem",   3'd3, 1'b1, 3'd5, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 2'b10, 2'b00);
        fwdVec("fwd_wb",    3'd3, 1'b1, 3'd5, 1'b0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 2'b01, 2'b00);
        fwdVec("fwd_zero",  3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 2'b00, 2'b01);
        fwdVec("fwd_vr0",   3'd0, 1'b1, 3'd6, 1'b1, 3'd0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 2'b10, 2'b01);
        fwdVec("fwd_mdis",  3'd4, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 2'b01, 2'b01);
        fwdVec("fwd_none",  3'd4, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 2'b00, 2'b00);
        fwdVec("fwd_split", 3'd7, 1'b0, 3'd7, 1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 2'b01, 2'b10);
        clearInputs();
        tick();

        // load-use near misses, then a 3-cycle load-use stall
        MemtoRegE = 1'b1; WA3E = 3'd2; WF3E = 1'b1; RA2D = 3'd2; RF2D = 1'b0;
        #1; checkVal("lu_filediff", 32'(ctl), 32'(CTL_IDLE));
        WA3E = 3'd0; WF3E = 1'b0; RA2D = 3'd0; RF2D = 1'b0;
        #1; checkVal("lu_zeroreg", 32'(ctl), 32'(CTL_IDLE));
        MemtoRegE = 1'b0; WA3E = 3'd2; RA2D = 3'd2;
        #1; checkVal("lu_noload", 32'(ctl), 32'(CTL_IDLE));
        MemtoRegE = 1'b1;
        #1; checkVal("lu_c1", 32'(ctl), 32'(CTL_LOAD));
        tick();
        MemtoRegE = 1'b0;
        #1; checkVal("lu_c2", 32'(ctl), 32'(CTL_LOAD));
        tick();
        checkVal("lu_c3", 32'(ctl), 32'(CTL_LOAD));
        tick();
        checkVal("lu_done", 32'(ctl), 32'(CTL_IDLE));
        checkVal("lu_count", 32'(StallCount), 32'd3);
        clearInputs();
        tick();

        // taken branch aborts the load stall in its second cycle
        MemtoRegE = 1'b1; WA3E = 3'd4; RA1D = 3'd4;
        #1; checkVal("br_c1", 32'(ctl), 32'(CTL_LOAD));
        tick();
        MemtoRegE = 1'b0; BranchTakenE = 1'b1;
        #1; checkVal("br_flush", 32'(ctl), 32'(CTL_FLUSH));
        tick();
        BranchTakenE = 1'b0;
        #1; checkVal("br_run", 32'(ctl), 32'(CTL_IDLE));
        checkVal("br_count", 32'(StallCount), 32'd4);
        clearInputs();
        tick();

        // Busy for 5 cycles while two load-stall cycles remain
        MemtoRegE = 1'b1; WA3E = 3'd5; WF3E = 1'b1; RA1D = 3'd5; RF1D = 1'b1;
        #1; checkVal("bz_c1", 32'(ctl), 32'(CTL_LOAD));
        tick();
        MemtoRegE = 1'b0; Busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; checkVal($sformatf("bz_freeze%0d", i), 32'(ctl), 32'(CTL_BUSY));
            tick();
        end
        Busy = 1'b0;
        #1; checkVal("bz_resume1", 32'(ctl), 32'(CTL_LOAD));
        tick();
        checkVal("bz_resume2", 32'(ctl), 32'(CTL_LOAD));
        tick();
        checkVal("bz_done", 32'(ctl), 32'(CTL_IDLE));
        checkVal("bz_count", 32'(StallCount), 32'd12);
        checkVal("bz_timeout", 32'(BusyTimeout), 32'd1);
        clearInputs();
        tick();

        // reset in the middle of a load stall
        MemtoRegE = 1'b1; WA3E = 3'd3; RA2D = 3'd3;
        #1; checkVal("rs_c1", 32'(ctl), 32'(CTL_LOAD));
        tick();
        MemtoRegE = 1'b0;
        #1; checkVal("rs_c2", 32'(ctl), 32'(CTL_LOAD));
        rst_n = 1'b0;
        #1; checkVal("rs_low", 32'(ctl), 32'(CTL_FLUSH));
        tick();
        rst_n = 1'b1;
        #1; checkVal("rs_run", 32'(ctl), 32'(CTL_IDLE));
        checkVal("rs_count", 32'(StallCount), 32'd0);
        checkVal("rs_timeout", 32'(BusyTimeout), 32'd0);
        clearInputs();
        tick();

        // timeout: 3 busy cycles stay clear, 4 set the sticky flag
        Busy = 1'b1;
        repeat (3) tick();
        Busy = 1'b0;
        #1; checkVal("to_three", 32'(BusyTimeout), 32'd0);
        tick();
        Busy = 1'b1;
        repeat (4) tick();
        Busy = 1'b0;
        #1; checkVal("to_four", 32'(BusyTimeout), 32'd1);
        checkVal("to_ctl", 32'(ctl), 32'(CTL_IDLE));
        repeat (3) tick();
        checkVal("to_sticky", 32'(BusyTimeout), 32'd1);

        // Busy together with a branch: flush only once Busy drops
        Busy = 1'b1; BranchTakenE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; checkVal($sformatf("bb_busy%0d", i), 32'(ctl), 32'(CTL_BUSY));
            tick();
        end
        Busy = 1'b0;
        #1; checkVal("bb_flush", 32'(ctl), 32'(CTL_FLUSH));
        tick();
        BranchTakenE = 1'b0;
        #1; checkVal("bb_run", 32'(ctl), 32'(CTL_IDLE));
        checkVal("bb_count", 32'(StallCount), 32'd9);

        // stall counter saturates at all ones
        Busy = 1'b1;
        repeat (8) tick();
        Busy = 1'b0;
        #1; checkVal("sat_count", 32'(StallCount), 32'd15);
        Busy = 1'b1;
        tick();
        Busy = 1'b0;
        #1; checkVal("sat_hold", 32'(StallCount), 32'd15);

        // only reset clears the timeout flag
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1; checkVal("end_timeout", 32'(BusyTimeout), 32'd0);
        checkVal("end_count", 32'(StallCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
